// File: rtl/uart_pkg.sv
// Shared UART timing helpers: rounding divider math and divider sanity check,
// used by the baud generator and available to the transmitter and receiver.
package uart_pkg;

  localparam int unsigned MIN_DIV = 2;

  // Integer divide rounded to nearest, for clock-to-baud divider ratios.
  function automatic int unsigned round_div(input int unsigned num, input int unsigned den);
    return (num + den / 2) / den;
  endfunction

  function automatic bit div_ok(input int unsigned div);
    return div >= MIN_DIV;
  endfunction

endpackage

// File: rtl/baud_gen_if.sv
// Timing strobes from the baud generator to the UART transmitter and receiver.
interface baud_gen_if;
  logic Tx_en;
  logic Rx_en;

  modport master (output Tx_en, output Rx_en);
  modport slave  (input  Tx_en, input  Rx_en);
endinterface

// File: rtl/clk_div_strobe.sv
// Free-running divide-by-DIV counter emitting a registered one-cycle strobe
// on every DIV-th clock after reset release.
module clk_div_strobe
  import uart_pkg::*;
#(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic strobe
);

    localparam int unsigned         CNT_W    = $clog2(DIV);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DIV - 1);

    if (!div_ok(DIV)) begin : g_div_too_small
        $error("clk_div_strobe: DIV must be at least 2");
    end

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             strobe_d, strobe_q;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        cnt_d    = cnt_q + 1'b1;
        strobe_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            strobe_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            cnt_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe = strobe_q;

endmodule

// File: rtl/baud_gen.sv
// UART baud-rate enable generator: Tx_en once per bit, Rx_en RX_OVERSAMPLE
// times per bit, each from its own free-running divider.
module baud_gen
  import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ   = 10_000_000,
    parameter int unsigned BAUD          = 9600,
    parameter int unsigned RX_OVERSAMPLE = 1
) (
    input  logic              clk,
    input  logic              reset,
    baud_gen_if.master        bg
);

    localparam int unsigned TX_DIV = round_div(CLK_FREQ_HZ, BAUD);
    localparam int unsigned RX_DIV = round_div(CLK_FREQ_HZ, BAUD * RX_OVERSAMPLE);

    if (RX_OVERSAMPLE != 1 && RX_OVERSAMPLE != 16) begin : g_bad_oversample
        $error("baud_gen: RX_OVERSAMPLE must be 1 or 16");
    end

    clk_div_strobe #(.DIV(TX_DIV)) u_tx_div (
        .clk    (clk),
        .reset  (reset),
        .strobe (bg.Tx_en)
    );

    clk_div_strobe #(.DIV(RX_DIV)) u_rx_div (
        .clk    (clk),
        .reset  (reset),
        .strobe (bg.Rx_en)
    );

endmodule

// File: tb/tb_baud_gen.sv
// Self-checking bench for baud_gen: default and 16x-oversample instances share
// clock and reset; outputs compared every cycle against a cycle-count model.
module tb_baud_gen;

    localparam int TX_DIV   = 1042;
    localparam int RX16_DIV = 65;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    baud_gen_if bg1 ();
    baud_gen_if bg16 ();

    baud_gen dut1 (
        .clk   (clk),
        .reset (reset),
        .bg    (bg1)
    );

    baud_gen #(.RX_OVERSAMPLE(16)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bg    (bg16)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n        = 0;   // rising edges seen with reset high since last release

    typedef struct {
        int   cyc;
        logic tx;
        logic rx16;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int cyc, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
        end
    endtask

    // Strobe is high during cycle k exactly when k is a positive multiple of the divider.
    function automatic logic model_pulse(input int cyc, input int div);
        return (cyc > 0) && (cyc % div == 0);
    endfunction

    task automatic check_all();
        check("tx",    n, bg1.Tx_en,  model_pulse(n, TX_DIV));
        check("rx",    n, bg1.Rx_en,  model_pulse(n, TX_DIV));
        check("tx16",  n, bg16.Tx_en, model_pulse(n, TX_DIV));
        check("rx16",  n, bg16.Rx_en, model_pulse(n, RX16_DIV));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (reset) n++;
        check_all();
    endtask

    task automatic assert_reset();
        reset = 1'b0;
        n     = 0;
        #1;
        check_all();
    endtask

    task automatic release_reset();
        reset = 1'b1;
    endtask

    initial begin
        int vi;
        int pulses;
        int last_pulse;
        logic prev_tx;

        vecs[0]  = '{cyc: 1,    tx: 1'b0, rx16: 1'b0};
        vecs[1]  = '{cyc: 64,   tx: 1'b0, rx16: 1'b0};
        vecs[2]  = '{cyc: 65,   tx: 1'b0, rx16: 1'b1};
        vecs[3]  = '{cyc: 66,   tx: 1'b0, rx16: 1'b0};
        vecs[4]  = '{cyc: 130,  tx: 1'b0, rx16: 1'b1};
        vecs[5]  = '{cyc: 1040, tx: 1'b0, rx16: 1'b1};
        vecs[6]  = '{cyc: 1041, tx: 1'b0, rx16: 1'b0};
        vecs[7]  = '{cyc: 1042, tx: 1'b1, rx16: 1'b0};
        vecs[8]  = '{cyc: 1043, tx: 1'b0, rx16: 1'b0};
        vecs[9]  = '{cyc: 2083, tx: 1'b0, rx16: 1'b0};
        vecs[10] = '{cyc: 2084, tx: 1'b1, rx16: 1'b0};
        vecs[11] = '{cyc: 2085, tx: 1'b0, rx16: 1'b0};

        // Reset held for 3 clocks: all strobes low.
        #1;
        check_all();
        repeat (3) tick();

        // Defaults over 20 periods, with table vectors and pulse spacing.
        release_reset();
        vi         = 0;
        pulses     = 0;
        last_pulse = 0;
        prev_tx    = 1'b0;
        for (int c = 1; c <= 20 * TX_DIV; c++) begin
            tick();
            if (vi < 12 && n == vecs[vi].cyc) begin
                check("vec_tx",   n, bg1.Tx_en,  vecs[vi].tx);
                check("vec_rx",   n, bg1.Rx_en,  vecs[vi].tx);
                check("vec_rx16", n, bg16.Rx_en, vecs[vi].rx16);
                vi++;
            end
            if (bg1.Tx_en) begin
                pulses++;
                check("tx_spacing", n, n - last_pulse, TX_DIV);
                check("tx_no_double", n, prev_tx, 1'b0);
                last_pulse = n;
            end
            prev_tx = bg1.Tx_en;
        end
        check("vec_count", n, vi, 12);
        check("tx_pulses_20", n, pulses, 20);

        // Reset mid-count at cycle 500, held 2 cycles: full latency again.
        assert_reset();
        tick();
        release_reset();
        while (n < 500) tick();
        assert_reset();
        repeat (2) tick();
        release_reset();
        pulses = 0;
        while (n < TX_DIV + 10) begin
            tick();
            if (bg1.Tx_en) begin
                pulses++;
                check("tx_after_midreset", n, n, TX_DIV);
            end
        end
        check("tx_pulses_after_midreset", n, pulses, 1);

        // Reset landing on a strobe-high cycle drops it without a clock edge.
        assert_reset();
        tick();
        release_reset();
        while (n < TX_DIV) tick();
        check("tx_high_before_drop", n, bg1.Tx_en, 1'b1);
        reset = 1'b0;
        #1;
        check("tx_async_drop", n, bg1.Tx_en, 1'b0);
        check("rx_async_drop", n, bg1.Rx_en, 1'b0);
        n = 0;
        tick();
        release_reset();
        while (n < RX16_DIV) tick();
        check("rx16_high_before_drop", n, bg16.Rx_en, 1'b1);
        reset = 1'b0;
        #1;
        check("rx16_async_drop", n, bg16.Rx_en, 1'b0);
        n = 0;
        tick();

        // Random run lengths, reset holds and release phases.
        for (int it = 0; it < 6; it++) begin
            int unsigned len;
            int unsigned hold;
            len  = $urandom_range(40, 3000);
            hold = $urandom_range(1, 3);
            #($urandom_range(0, 3));
            release_reset();
            repeat (len) tick();
            assert_reset();
            repeat (hold) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
